mem_access_unit: RTL and testbench

//  Memory stage directly downstream of the ALU. Takes the ALU effective address for
//  lb/lh/lw/sb/sh/sw and runs one multi-cycle access on a word-wide data-memory bus

---
 rtl/mem_access_unit.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory stage behind the ALU. Runs one req/ack access per
//                lb/lh/lw/sb/sh/sw, sign-extends loads, drives byte lanes for
//                stores, and passes non-memory opcodes through in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rt_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [5:0] C_OP_LB = 6'h20;
  localparam logic [5:0] C_OP_LH = 6'h21;
  localparam logic [5:0] C_OP_LW = 6'h23;
  localparam logic [5:0] C_OP_SB = 6'h28;
  localparam logic [5:0] C_OP_SH = 6'h29;
  localparam logic [5:0] C_OP_SW = 6'h2B;

  localparam int             CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Access size encoding kept with the latched request
  localparam logic [1:0] C_SZ_BYTE = 2'd0;
  localparam logic [1:0] C_SZ_HALF = 2'd1;
  localparam logic [1:0] C_SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         lo_q, lo_d;
  logic               ovalid_q, ovalid_d;
  logic [31:0]        load_q, load_d;
  logic               mis_q, mis_d;
  logic               berr_q, berr_d;

  logic               w_is_load, w_is_store, w_mis;
  logic [1:0]         w_size;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_ext;

  // Decode the incoming opcode into size, direction, alignment and lane layout
  always_comb begin
    w_is_load  = (opcode == C_OP_LB) || (opcode == C_OP_LH) || (opcode == C_OP_LW);
    w_is_store = (opcode == C_OP_SB) || (opcode == C_OP_SH) || (opcode == C_OP_SW);
    w_size     = C_SZ_WORD;
    w_be       = 4'b1111;
    w_wdata    = rt_reg;
    w_mis      = (ALU_result[1:0] != 2'b00);
    if (opcode == C_OP_LB || opcode == C_OP_SB) begin
      w_size = C_SZ_BYTE;
      w_mis  = 1'b0;
    end else if (opcode == C_OP_LH || opcode == C_OP_SH) begin
      w_size = C_SZ_HALF;
      w_mis  = ALU_result[0];
    end
    if (opcode == C_OP_SB) begin
      w_be    = 4'b0001 << ALU_result[1:0];
      w_wdata = {4{rt_reg[7:0]}};
    end else if (opcode == C_OP_SH) begin
      w_be    = ALU_result[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{rt_reg[15:0]}};
    end
  end

  // Select and sign-extend the addressed byte/half of the returned word
  always_comb begin
    case (lo_q)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      C_SZ_BYTE: w_ext = {{24{w_byte[7]}}, w_byte};
      C_SZ_HALF: w_ext = {{16{w_half[15]}}, w_half};
      default:   w_ext = mem_rdata;
    endcase
  end

  // Next-state and output logic; response flags default low so they pulse once
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    lo_d     = lo_q;
    ovalid_d = 1'b0;
    load_d   = 32'd0;
    mis_d    = 1'b0;
    berr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((w_is_load || w_is_store) && !w_mis) begin
            state_d = S_ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = w_is_store;
            addr_d  = {ALU_result[31:2], 2'b00};
            be_d    = w_be;
            wdata_d = w_wdata;
            size_d  = w_size;
            lo_d    = ALU_result[1:0];
          end else begin
            state_d  = S_RESP;
            ovalid_d = 1'b1;
            mis_d    = (w_is_load || w_is_store) && w_mis;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the final allowed cycle still completes the access
        if (mem_ack) begin
          state_d  = S_RESP;
          req_d    = 1'b0;
          we_d     = 1'b0;
          ovalid_d = 1'b1;
          load_d   = we_q ? 32'd0 : w_ext;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d  = S_RESP;
          req_d    = 1'b0;
          we_d     = 1'b0;
          ovalid_d = 1'b1;
          berr_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      size_q   <= C_SZ_BYTE;
      lo_q     <= 2'd0;
      ovalid_q <= 1'b0;
      load_q   <= 32'd0;
      mis_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      lo_q     <= lo_d;
      ovalid_q <= ovalid_d;
      load_q   <= load_d;
      mis_q    <= mis_d;
      berr_q   <= berr_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;
  assign out_valid  = ovalid_q;
  assign load_data  = load_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with a behavioural
//                model of each memory operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;
  localparam logic [5:0] ADDI = 6'h08, RTYPE = 6'h00, BEQ = 6'h04;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] ALU_result = 32'd0;
  logic [31:0] rt_reg = 32'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        out_valid, misaligned, bus_error;
  logic [31:0] load_data;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ALU_result(ALU_result), .rt_reg(rt_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .load_data(load_data), .misaligned(misaligned),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          reqs;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic        chk_wdata;
    logic [31:0] load;
    logic        mis;
    logic        berr;
  } exp_t;

  // Behavioural model: what one operation should look like on the bus and at the output
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] rt, input logic [31:0] rdata,
                                 input int ackc);
    exp_t e;
    int   sz, v, off;
    logic is_ld, is_st;
    e = '{default: 0};
    is_ld = (op == LB) || (op == LH) || (op == LW);
    is_st = (op == SB) || (op == SH) || (op == SW);
    sz = (op == LB || op == SB) ? 1 : (op == LH || op == SH) ? 2 : 4;
    off = int'(a % 4);
    e.lat = 1;
    if (!(is_ld || is_st)) return e;
    if ((a % sz) != 0) begin
      e.mis = 1'b1;
      return e;
    end
    e.addr = a - off;
    e.we   = is_st;
    if (ackc >= 1 && ackc <= TO) begin
      e.reqs = ackc;
      e.lat  = ackc + 1;
    end else begin
      e.reqs = TO;
      e.lat  = TO + 1;
      e.berr = 1'b1;
    end
    if (is_st) begin
      e.chk_wdata = 1'b1;
      if (sz == 1) begin
        e.be    = 4'(1 << off);
        e.wdata = rt[7:0] * 32'h01010101;
      end else if (sz == 2) begin
        e.be    = (off == 2) ? 4'b1100 : 4'b0011;
        e.wdata = rt[15:0] * 32'h00010001;
      end else begin
        e.be    = 4'b1111;
        e.wdata = rt;
      end
    end else begin
      e.be = 4'b1111;
      if (!e.berr) begin
        v = int'(rdata >> (8 * off));
        if (sz == 1) begin
          v = v & 255;
          if (v > 127) v = v - 256;
          e.load = 32'(v);
        end else if (sz == 2) begin
          v = v & 65535;
          if (v > 32767) v = v - 65536;
          e.load = 32'(v);
        end else begin
          e.load = rdata;
        end
      end
    end
    return e;
  endfunction

  // Observations of the most recent run_op
  int          o_lat, o_reqs;
  logic [31:0] o_addr, o_wdata, o_load;
  logic [3:0]  o_be;
  logic        o_we, o_we_unstable, o_mis, o_berr, o_post_ok;

  // Issue one operation and play the memory side; ackc=0 means never acknowledge
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                        input logic [31:0] rdata, input int ackc, input bit noise);
    o_lat = -1; o_reqs = 0; o_addr = 0; o_be = 0; o_wdata = 0; o_we = 0;
    o_we_unstable = 0; o_load = 0; o_mis = 0; o_berr = 0; o_post_ok = 0;
    in_valid = 1'b1; opcode = op; ALU_result = a; rt_reg = rt; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      mem_ack = 1'b0;
      if (out_valid) begin
        o_lat = cyc; o_load = load_data; o_mis = misaligned; o_berr = bus_error;
        in_valid = 1'b0;
        break;
      end
      if (mem_req) begin
        o_reqs++;
        if (o_reqs == 1) begin
          o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_we !== o_we) begin
          o_we_unstable = 1'b1;
        end
        if (cyc == ackc) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
      end
      if (noise) begin
        in_valid = 1'b1; opcode = ADDI; ALU_result = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o_post_ok = !out_valid && in_ready && (load_data == 0) && !misaligned && !bus_error && !mem_req;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_req, mem_we, out_valid, misaligned, bus_error} !== 6'b100000 ||
        mem_addr !== 0 || mem_be !== 0 || mem_wdata !== 0 || load_data !== 0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b req=%b we=%b ov=%b mis=%b berr=%b addr=%h be=%b wd=%h ld=%h (want rdy=1, rest 0)",
               in_ready, mem_req, mem_we, out_valid, misaligned, bus_error, mem_addr, mem_be, mem_wdata, load_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    exp_t e;
    e = model(LW, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    run_op(LW, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    checks++;
    if (o_lat !== 4 || o_lat !== e.lat) begin
      failures++; $display("FAIL lw_latency: got %0d want 4", o_lat);
    end
    checks++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0 || o_reqs !== 3) begin
      failures++; $display("FAIL lw_bus: addr=%h be=%b we=%b reqs=%0d want 100/1111/0/3", o_addr, o_be, o_we, o_reqs);
    end
    checks++;
    if (o_load !== 32'hDEADBEEF || o_mis !== 0 || o_berr !== 0) begin
      failures++; $display("FAIL lw_data: ld=%h mis=%b berr=%b want deadbeef/0/0", o_load, o_mis, o_berr);
    end
    checks++;
    if (!o_post_ok) begin
      failures++; $display("FAIL lw_post: out_valid/flags not cleared after response (got ok=%b want 1)", o_post_ok);
    end
  endtask

  task automatic test_lb();
    run_op(LB, 32'h103, 32'h0, 32'h80123456, 1, 1'b0);
    checks++;
    if (o_load !== 32'hFFFFFF80 || o_addr !== 32'h100 || o_lat !== 2) begin
      failures++; $display("FAIL lb_103: ld=%h addr=%h lat=%0d want ffffff80/100/2", o_load, o_addr, o_lat);
    end
    run_op(LB, 32'h101, 32'h0, 32'h80123456, 2, 1'b0);
    checks++;
    if (o_load !== 32'h00000034 || o_lat !== 3) begin
      failures++; $display("FAIL lb_101: ld=%h lat=%0d want 00000034/3", o_load, o_lat);
    end
    run_op(LH, 32'h102, 32'h0, 32'h80123456, 1, 1'b0);
    checks++;
    if (o_load !== 32'hFFFF8012) begin
      failures++; $display("FAIL lh_102: ld=%h want ffff8012", o_load);
    end
  endtask

  task automatic test_sh();
    run_op(SH, 32'h22, 32'h1234ABCD, 32'hFFFFFFFF, 2, 1'b0);
    checks++;
    if (o_we !== 1'b1 || o_addr !== 32'h20 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD) begin
      failures++; $display("FAIL sh_bus: we=%b addr=%h be=%b wd=%h want 1/20/1100/abcdabcd", o_we, o_addr, o_be, o_wdata);
    end
    checks++;
    if (o_load !== 0 || o_lat !== 3 || o_we_unstable) begin
      failures++; $display("FAIL sh_resp: ld=%h lat=%0d we_unstable=%b want 0/3/0", o_load, o_lat, o_we_unstable);
    end
  endtask

  task automatic test_misaligned();
    run_op(LW, 32'h102, 32'h0, 32'h0, 1, 1'b0);
    checks++;
    if (o_reqs !== 0 || o_lat !== 1 || o_mis !== 1 || o_berr !== 0 || o_load !== 0) begin
      failures++; $display("FAIL lw_misaligned: reqs=%0d lat=%0d mis=%b berr=%b ld=%h want 0/1/1/0/0",
                           o_reqs, o_lat, o_mis, o_berr, o_load);
    end
    run_op(SH, 32'h31, 32'h5, 32'h0, 1, 1'b0);
    checks++;
    if (o_reqs !== 0 || o_lat !== 1 || o_mis !== 1) begin
      failures++; $display("FAIL sh_misaligned: reqs=%0d lat=%0d mis=%b want 0/1/1", o_reqs, o_lat, o_mis);
    end
  endtask

  task automatic test_timeout();
    run_op(LW, 32'h40, 32'h0, 32'h0, 0, 1'b0);
    checks++;
    if (o_reqs !== TO || o_berr !== 1 || o_lat !== TO + 1 || o_load !== 0) begin
      failures++; $display("FAIL timeout_noack: reqs=%0d berr=%b lat=%0d ld=%h want %0d/1/%0d/0",
                           o_reqs, o_berr, o_lat, o_load, TO, TO + 1);
    end
    run_op(LW, 32'h40, 32'h0, 32'h13572468, TO, 1'b0);
    checks++;
    if (o_reqs !== TO || o_berr !== 0 || o_load !== 32'h13572468) begin
      failures++; $display("FAIL timeout_ack_last: reqs=%0d berr=%b ld=%h want %0d/0/13572468",
                           o_reqs, o_berr, o_load, TO);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1'b1; opcode = LW; ALU_result = 32'h80;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL rstmid_req_start: req=%b want 1", mem_req);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_req_drop: req=%b ov=%b want 0/0", mem_req, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = (i == 1);
      if (out_valid || mem_req) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_abandon: busy_cycles=%0d rdy=%b want 0/1", seen, in_ready);
    end
  endtask

  task automatic test_nonmem();
    run_op(ADDI, 32'h104, 32'hFFFF, 32'h0, 1, 1'b0);
    checks++;
    if (o_lat !== 1 || o_reqs !== 0 || o_load !== 0 || o_mis !== 0 || o_berr !== 0 || !o_post_ok) begin
      failures++; $display("FAIL addi_pass: lat=%0d reqs=%0d ld=%h mis=%b berr=%b post=%b want 1/0/0/0/0/1",
                           o_lat, o_reqs, o_load, o_mis, o_berr, o_post_ok);
    end
  endtask

  // Random operations, with in_valid noise while busy to show it is not queued
  task automatic test_random();
    logic [5:0]  ops [9];
    logic [5:0]  op;
    logic [31:0] a, rt, rd;
    int          ackc;
    exp_t        e;
    ops = '{LB, LH, LW, SB, SH, SW, ADDI, RTYPE, BEQ};
    for (int n = 0; n < 60; n++) begin
      op   = ops[$urandom_range(0, 8)];
      a    = $urandom;
      rt   = $urandom;
      rd   = $urandom;
      ackc = $urandom_range(0, TO + 1);
      e    = model(op, a, rt, rd, ackc);
      run_op(op, a, rt, rd, ackc, n[0]);
      checks++;
      if (o_lat !== e.lat || o_reqs !== e.reqs || o_mis !== e.mis || o_berr !== e.berr ||
          o_load !== e.load || !o_post_ok || o_we_unstable) begin
        failures++;
        $display("FAIL rand_resp[%0d] op=%h a=%h: lat=%0d/%0d reqs=%0d/%0d mis=%b/%b berr=%b/%b ld=%h/%h post=%b (got/want)",
                 n, op, a, o_lat, e.lat, o_reqs, e.reqs, o_mis, e.mis, o_berr, e.berr, o_load, e.load, o_post_ok);
      end
      if (e.reqs > 0) begin
        checks++;
        if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we || (e.chk_wdata && o_wdata !== e.wdata)) begin
          failures++;
          $display("FAIL rand_bus[%0d] op=%h a=%h: addr=%h/%h be=%b/%b we=%b/%b wd=%h/%h (got/want)",
                   n, op, a, o_addr, e.addr, o_be, e.be, o_we, e.we, o_wdata, e.wdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    run_op(SB, 32'h7, 32'h000000A5, 32'h0, 1, 1'b1);
    checks++;
    if (o_be !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_lat !== 2) begin
      failures++; $display("FAIL b2b_sb: be=%b wd=%h lat=%0d want 1000/a5a5a5a5/2", o_be, o_wdata, o_lat);
    end
    e = model(LH, 32'h10, 32'h0, 32'h0000F00D, 1);
    run_op(LH, 32'h10, 32'h0, 32'h0000F00D, 1, 1'b1);
    checks++;
    if (o_load !== e.load || o_load !== 32'hFFFFF00D || o_lat !== 2) begin
      failures++; $display("FAIL b2b_lh: ld=%h lat=%0d want fffff00d/2", o_load, o_lat);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_nonmem();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
